// File: rtl/inst_mem_loader.sv
// Instruction memory with a valid/ready program-load port and a 1-cycle registered fetch port.
// Flags bad fetches, substitutes NOP for unloaded words and freezes after returning a HALT word.
module inst_mem_loader #(
    parameter int          DEPTH       = 64,
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'b101101
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    input  logic                         fetch_req,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr,
    output logic [DATA_WIDTH-1:0]        inst_out,
    output logic                         inst_valid,
    output logic                         addr_err,
    output logic                         prog_loaded,
    output logic                         halt_seen,
    output logic [$clog2(DEPTH+1)-1:0]   load_count
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [DATA_WIDTH-1:0]   inst_reg;
    logic                    valid_reg;
    logic                    err_reg;
    logic                    loaded_reg;
    logic                    halt_reg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    load_fire;
    logic [IDX_W-1:0]        fetch_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    unloaded;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    is_halt;

    assign load_ready   = (state_reg == LOAD) && (count_reg < CNT_W'(DEPTH));
    assign load_fire    = load_valid && load_ready;

    // Index compares use the full word-index width so high addresses never alias into the array.
    assign fetch_idx    = fetch_addr[ADDR_WIDTH-1:2];
    assign misaligned   = |fetch_addr[1:0];
    assign out_of_range = fetch_idx >= IDX_W'(DEPTH);
    assign unloaded     = fetch_idx >= IDX_W'(count_reg);
    assign rd_word      = mem[fetch_idx[MEM_AW-1:0]];
    assign is_halt      = rd_word[DATA_WIDTH-1 -: 6] == HALT_OPCODE;

    // Memory has no reset so its contents survive a reset; writes are blocked on the reset edge.
    always_ff @(posedge clk) begin
        if (reset && load_fire) begin
            mem[count_reg[MEM_AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= LOAD;
            count_reg  <= '0;
            inst_reg   <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
            loaded_reg <= 1'b0;
            halt_reg   <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    if (load_fire) begin
                        count_reg <= count_reg + CNT_W'(1);
                        if (load_last || (count_reg == CNT_W'(DEPTH - 1))) begin
                            state_reg  <= RUN;
                            loaded_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fetch_req) begin
                        valid_reg <= 1'b1;
                        if (misaligned || out_of_range) begin
                            inst_reg <= '0;
                            err_reg  <= 1'b1;
                        end else if (unloaded) begin
                            inst_reg <= '0;
                            err_reg  <= 1'b0;
                        end else begin
                            inst_reg <= rd_word;
                            err_reg  <= 1'b0;
                            if (is_halt) begin
                                halt_reg  <= 1'b1;
                                state_reg <= HALTED;
                            end
                        end
                    end else begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                    end
                end
                HALTED: begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign inst_out    = inst_reg;
    assign inst_valid  = valid_reg;
    assign addr_err    = err_reg;
    assign prog_loaded = loaded_reg;
    assign halt_seen   = halt_reg;
    assign load_count  = count_reg;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed scenarios plus a randomized run checked
// against a word-array model of the load/fetch rules.
module tb_inst_mem_loader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        addr_err;
    logic        prog_loaded;
    logic        halt_seen;
    logic [6:0]  load_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    int          m_cnt;
    bit          m_loaded;
    bit          m_halted;
    bit          m_halt_seen;
    logic [31:0] m_out;
    bit          m_valid;
    bit          m_err;

    inst_mem_loader dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .inst_out(inst_out), .inst_valid(inst_valid), .addr_err(addr_err),
        .prog_loaded(prog_loaded), .halt_seen(halt_seen), .load_count(load_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] safe_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b101101) w[31] = 1'b0;
        return w;
    endfunction

    // Advance one clock edge, applying the load/fetch rules to the model from the current inputs.
    task automatic step();
        longint unsigned idx;
        if (!reset) begin
            m_cnt = 0; m_loaded = 0; m_halted = 0; m_halt_seen = 0;
            m_out = 0; m_valid = 0; m_err = 0;
        end else if (!m_loaded) begin
            m_valid = 0; m_err = 0;
            if (load_valid && m_cnt < DEPTH) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (load_last || m_cnt == DEPTH) m_loaded = 1;
            end
        end else if (m_halted || !fetch_req) begin
            m_valid = 0; m_err = 0;
        end else begin
            idx = longint'(fetch_addr) / 4;
            m_valid = 1;
            if (fetch_addr % 4 != 0 || idx >= DEPTH) begin
                m_out = 0; m_err = 1;
            end else if (idx >= m_cnt) begin
                m_out = 0; m_err = 0;
            end else begin
                m_out = m_mem[idx]; m_err = 0;
                if (m_out[31:26] == 6'b101101) begin
                    m_halted = 1; m_halt_seen = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 0; load_last = 0; load_data = 0; fetch_req = 0; fetch_addr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        step();
        reset = 1;
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        load_valid = 1; load_data = w; load_last = last;
        step();
        idle_inputs();
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1; fetch_addr = a;
        step();
        fetch_req = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        apply_reset();
        total_cnt++; if (inst_out !== 32'h0) $display("FAIL reset_inst_out got %h want 0", inst_out); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0 || addr_err !== 1'b0) $display("FAIL reset_flags valid %b err %b want 0 0", inst_valid, addr_err); else pass_cnt++;
        total_cnt++; if (prog_loaded !== 1'b0 || halt_seen !== 1'b0) $display("FAIL reset_status loaded %b halt %b want 0 0", prog_loaded, halt_seen); else pass_cnt++;
        total_cnt++; if (load_count !== 7'd0) $display("FAIL reset_count got %0d want 0", load_count); else pass_cnt++;
        total_cnt++; if (load_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", load_ready); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_load_basic();
        logic [31:0] prog [3] = '{32'h20010005, 32'h20020003, 32'h00221820};
        load_last = 1; step(); load_last = 0;
        total_cnt++; if (load_count !== 7'd0 || prog_loaded !== 1'b0) $display("FAIL lone_last count %0d loaded %b want 0 0", load_count, prog_loaded); else pass_cnt++;
        fetch(32'h0);
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL fetch_in_load valid %b want 0", inst_valid); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            load_word(prog[i], i == 2);
            total_cnt++; if (load_count !== 7'(i + 1)) $display("FAIL load_count_%0d got %0d want %0d", i, load_count, i + 1); else pass_cnt++;
            $display("load word %0d = %h", i, prog[i]);
        end
        total_cnt++; if (prog_loaded !== 1'b1 || load_ready !== 1'b0) $display("FAIL load_done loaded %b ready %b want 1 0", prog_loaded, load_ready); else pass_cnt++;
        load_word(32'hDEADBEEF, 1'b0);
        total_cnt++; if (load_count !== 7'd3) $display("FAIL load_after_run count %0d want 3", load_count); else pass_cnt++;
    endtask

    task automatic test_fetch_basic();
        logic [31:0] exp [3] = '{32'h20010005, 32'h20020003, 32'h00221820};
        fetch_req = 1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            step();
            total_cnt++;
            if (inst_valid !== 1'b1 || inst_out !== exp[i] || addr_err !== 1'b0)
                $display("FAIL fetch_%0d valid %b out %h err %b want 1 %h 0", i, inst_valid, inst_out, addr_err, exp[i]);
            else pass_cnt++;
            $display("fetch %h -> %h", fetch_addr, inst_out);
        end
        fetch_req = 0; step();
        total_cnt++; if (inst_valid !== 1'b0 || inst_out !== exp[2]) $display("FAIL fetch_idle valid %b out %h want 0 %h", inst_valid, inst_out, exp[2]); else pass_cnt++;
    endtask

    task automatic test_addr_err();
        logic [31:0] addrs [5] = '{32'h2, 32'h100, 32'hC, 32'h4000_0000, 32'h0000_0103};
        logic [31:0] exp_o [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bit          exp_e [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            fetch(addrs[i]);
            total_cnt++;
            if (inst_valid !== 1'b1 || inst_out !== exp_o[i] || addr_err !== exp_e[i])
                $display("FAIL addr_chk_%h valid %b out %h err %b want 1 %h %b", addrs[i], inst_valid, inst_out, addr_err, exp_o[i], exp_e[i]);
            else pass_cnt++;
            $display("fetch %h -> %h err %b", addrs[i], inst_out, addr_err);
        end
    endtask

    task automatic test_full_load();
        logic [31:0] words [DEPTH];
        apply_reset();
        load_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = safe_word();
            load_data = words[i];
            step();
        end
        total_cnt++; if (load_count !== 7'd64 || prog_loaded !== 1'b1 || load_ready !== 1'b0) $display("FAIL full_load count %0d loaded %b ready %b want 64 1 0", load_count, prog_loaded, load_ready); else pass_cnt++;
        load_data = ~words[DEPTH-1];
        step();
        idle_inputs();
        total_cnt++; if (load_count !== 7'd64) $display("FAIL load_65 count %0d want 64", load_count); else pass_cnt++;
        fetch(32'hFC);
        total_cnt++; if (inst_out !== words[DEPTH-1] || addr_err !== 1'b0) $display("FAIL last_word out %h err %b want %h 0", inst_out, addr_err, words[DEPTH-1]); else pass_cnt++;
        $display("full load: fetch 0xFC -> %h", inst_out);
    endtask

    task automatic run_halt_program();
        apply_reset();
        for (int i = 0; i < 4; i++) load_word(safe_word(), 1'b0);
        load_word(32'hB4221820, 1'b1);
    endtask

    task automatic test_halt();
        logic [31:0] first;
        run_halt_program();
        first = m_mem[0];
        fetch(32'h0);
        total_cnt++; if (inst_out !== first || halt_seen !== 1'b0) $display("FAIL pre_halt out %h halt %b want %h 0", inst_out, halt_seen, first); else pass_cnt++;
        fetch(32'h10);
        total_cnt++; if (inst_out !== 32'hB4221820 || inst_valid !== 1'b1 || halt_seen !== 1'b1) $display("FAIL halt_fetch out %h valid %b halt %b want b4221820 1 1", inst_out, inst_valid, halt_seen); else pass_cnt++;
        $display("halt fetch -> %h", inst_out);
        for (int i = 0; i < 3; i++) begin
            fetch(i == 2 ? 32'h2 : 32'h0);
            total_cnt++;
            if (inst_valid !== 1'b0 || addr_err !== 1'b0 || inst_out !== 32'hB4221820 || halt_seen !== 1'b1 || prog_loaded !== 1'b1)
                $display("FAIL halted_%0d valid %b err %b out %h halt %b loaded %b want 0 0 b4221820 1 1", i, inst_valid, addr_err, inst_out, halt_seen, prog_loaded);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] w;
        apply_reset();
        load_word(32'h11111111, 1'b0);
        load_word(32'h22222222, 1'b0);
        apply_reset();
        total_cnt++; if (load_count !== 7'd0 || load_ready !== 1'b1 || prog_loaded !== 1'b0) $display("FAIL reset_midload count %0d ready %b loaded %b want 0 1 0", load_count, load_ready, prog_loaded); else pass_cnt++;
        w = safe_word();
        load_word(w, 1'b1);
        fetch(32'h0);
        total_cnt++; if (inst_out !== w) $display("FAIL reload_word out %h want %h", inst_out, w); else pass_cnt++;
        fetch(32'h4);
        total_cnt++; if (inst_out !== 32'h0 || addr_err !== 1'b0) $display("FAIL stale_word out %h err %b want 0 0", inst_out, addr_err); else pass_cnt++;
        run_halt_program();
        fetch(32'h10);
        apply_reset();
        total_cnt++;
        if (halt_seen !== 1'b0 || inst_out !== 32'h0 || prog_loaded !== 1'b0 || load_ready !== 1'b1 || load_count !== 7'd0)
            $display("FAIL reset_halted halt %b out %h loaded %b ready %b count %0d want 0 0 0 1 0", halt_seen, inst_out, prog_loaded, load_ready, load_count);
        else pass_cnt++;
        $display("reset from halted done");
    endtask

    task automatic test_random_run();
        int n, budget, errs;
        apply_reset();
        n = $urandom_range(1, DEPTH);
        budget = 0;
        while (!m_loaded && budget < 1000) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = safe_word();
            load_last  = load_valid ? (m_cnt == n - 1) : 1'($urandom_range(0, 1));
            step();
            budget++;
        end
        idle_inputs();
        total_cnt++; if (!m_loaded || load_count !== 7'(m_cnt) || prog_loaded !== 1'b1) $display("FAIL rand_load count %0d loaded %b want %0d 1 (cycles %0d)", load_count, prog_loaded, m_cnt, budget); else pass_cnt++;
        $display("random load of %0d words", m_cnt);
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            fetch_req = 1'($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: fetch_addr = 32'($urandom_range(0, m_cnt - 1) * 4);
                1: fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                2: fetch_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
                default: fetch_addr = $urandom;
            endcase
            step();
            total_cnt++;
            if (inst_valid !== m_valid || inst_out !== m_out || addr_err !== m_err || halt_seen !== m_halt_seen) begin
                $display("FAIL rand_fetch_%0d addr %h got %b %h %b want %b %h %b", c, fetch_addr, inst_valid, inst_out, addr_err, m_valid, m_out, m_err);
                errs++;
            end else pass_cnt++;
            if (c % 50 == 0) $display("rand fetch %h req %b -> %h err %b", fetch_addr, fetch_req, inst_out, addr_err);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_basic();
        test_fetch_basic();
        test_addr_err();
        test_full_load();
        test_halt();
        test_reset_midrun();
        test_random_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Clocked, parametrised successor to the combinational instruction memory.
- Accepts a program over a valid/ready load port after reset, then serves word-aligned fetches with fixed 1-cycle latency.
- Flags out-of-range or misaligned fetches and detects the HALT instruction, freezing further fetch responses.
- Sits between the program source (testbench/boot loader) and the MIPS fetch stage.

Parameters:
- DEPTH, 64, number of instruction words stored.
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte-address width of fetch_addr.
- HALT_OPCODE, 6'b101101, opcode (word bits [DATA_WIDTH-1:DATA_WIDTH-6]) that marks end of program.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- load_valid  in  1  load word present.
- load_data  in  DATA_WIDTH  instruction word to store.
- load_last  in  1  qualifies final load word.
- load_ready  out  1  block accepts a load word this cycle.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  byte address of requested instruction.
- inst_out  out  DATA_WIDTH  fetched instruction (registered).
- inst_valid  out  1  inst_out valid this cycle.
- addr_err  out  1  pulse with inst_valid when the fetch was misaligned or out of range.
- prog_loaded  out  1  high once loading has completed (RUN or HALTED).
- halt_seen  out  1  sticky; set when a HALT word was returned.
- load_count  out  $clog2(DEPTH+1)  number of words loaded.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state<=LOAD; write pointer and load_count<=0.
  - inst_out<=0; inst_valid, addr_err, halt_seen, prog_loaded<=0.
  - Memory contents are not cleared.
- Reset mid-load or mid-run discards all progress identically.
- States: LOAD, RUN, HALTED.
- LOAD:
  - load_ready = (state==LOAD) && (load_count<DEPTH), combinational from registers.
  - Transfer occurs on load_valid && load_ready: mem[load_count]<=load_data; load_count<=load_count+1.
  - Go to RUN on the edge of a transfer with load_last==1, or on the transfer that makes load_count==DEPTH.
  - load_valid without load_ready is ignored; no write occurs.
  - fetch_req is ignored in LOAD: inst_valid stays 0.
  - load_last without load_valid has no effect.
- RUN:
  - load_ready=0; load_valid ignored; prog_loaded=1.
  - Fetch: on an edge with fetch_req==1, inst_valid<=1 the next cycle (1-cycle latency, one request per cycle, back-to-back allowed).
  - Word index = fetch_addr>>2.
  - addr_err case: fetch_addr[1:0]!=0, or index>=DEPTH. Result: inst_out<=0 (NOP), addr_err<=1.
  - Unloaded case: index>=load_count but <DEPTH. Result: inst_out<=0, addr_err<=0 (unloaded words read as NOP).
  - Otherwise inst_out<=mem[index], addr_err<=0.
  - fetch_req==0: inst_valid<=0, addr_err<=0; inst_out holds its last value.
  - HALT detect: if the word being returned (not an error/NOP substitute) has opcode==HALT_OPCODE, then in the same edge inst_out<=word, inst_valid<=1, halt_seen<=1, state<=HALTED.
- HALTED:
  - inst_valid and addr_err forced 0; fetch_req ignored; inst_out holds the HALT word.
  - halt_seen stays 1; prog_loaded stays 1.
  - Exit only via reset.
- load_count saturates at DEPTH; never wraps.
- Comparisons on index use full ADDR_WIDTH-2 bits, so no aliasing of high addresses.

Test Plan:
- Reset then load 3 words (0x20010005, 0x20020003, 0x00221820 with load_last) → load_count=3, prog_loaded=1 on the cycle after the third transfer, load_ready=0 thereafter.
- Fetch addr 0x0,0x4,0x8 back-to-back → inst_valid high 3 consecutive cycles, inst_out 0x20010005, 0x20020003, 0x00221820, each one cycle after its request.
- Fetch 0x2 (misaligned) and 0x100 (index 64, DEPTH=64) → inst_out=0, addr_err=1 with inst_valid=1. Fetch 0xC (unloaded index 3) → inst_out=0, addr_err=0.
- Load DEPTH words without load_last, with load_valid held high → exactly 64 transfers, auto-enter RUN. A 65th load_valid is not accepted.
- Load 0xB4221820 at index 4 (opcode 101101). Fetch 0x10 → inst_out=0xB4221820, inst_valid=1, halt_seen=1. Subsequent fetches of 0x0 → inst_valid=0, inst_out unchanged.
- Drive reset low for one edge during LOAD (after 2 words) and again in HALTED → all outputs return to reset values, load_count=0, state LOAD, load_ready=1 the cycle after reset releases.
